count16_ctrl: RTL and testbench

COUNT16_CTRL -- requirements
Module: count16_ctrl

---
 rtl/count16_ctrl.sv | 168 ++++++++++++++++
 tb/tb_count16_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/count16_ctrl.sv
// Test controller for a 4-bit loadable counter: loads, counts, lets the bus settle, then samples and checks it.
// Define COUNT16_CTRL_ERRCNT_EN to build the saturating failed-run counter on err_cnt; otherwise err_cnt is tied to 0.
module count16_ctrl #(
    parameter int SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       start,
    input  logic [3:0] start_val,
    input  logic [4:0] num_steps,
    input  logic [3:0] count_bus,
    output logic       load_l,
    output logic       enable_l,
    output logic [3:0] cnt_out,
    output logic       oe_l,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] exp_count,
    output logic [7:0] err_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COUNT,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t     state_q, state_d;
    logic [4:0] steps_q, steps_d;
    logic [3:0] settle_q, settle_d;
    logic [3:0] cnt_out_q, cnt_out_d;
    logic [3:0] exp_count_q, exp_count_d;
    logic       pass_q, pass_d;
    logic       load_l_q, load_l_d;
    logic       enable_l_q, enable_l_d;
    logic       oe_l_q, oe_l_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
`ifdef COUNT16_CTRL_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
`endif

    // Strobes are decoded from the next state so every output comes straight off a flop.
    always_comb begin
        state_d     = state_q;
        steps_d     = steps_q;
        settle_d    = settle_q;
        cnt_out_d   = cnt_out_q;
        exp_count_d = exp_count_q;
        pass_d      = pass_q;
`ifdef COUNT16_CTRL_ERRCNT_EN
        err_cnt_d   = err_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LOAD;
                    cnt_out_d   = start_val;
                    exp_count_d = start_val;
                    steps_d     = num_steps;
                    pass_d      = 1'b0;
                end
            end
            LOAD: begin
                if (steps_q != 5'd0) begin
                    state_d = COUNT;
                end else begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_LAST;
                end
            end
            COUNT: begin
                exp_count_d = exp_count_q + 4'd1;
                steps_d     = steps_q - 5'd1;
                if (steps_q == 5'd1) begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_LAST;
                end
            end
            SETTLE: begin
                if (settle_q == 4'd0) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            SAMPLE: begin
                state_d = DONE;
                pass_d  = (count_bus == exp_count_q);
`ifdef COUNT16_CTRL_ERRCNT_EN
                if ((count_bus != exp_count_q) && (err_cnt_q != 8'hFF)) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        load_l_d   = (state_d != LOAD);
        enable_l_d = (state_d != COUNT);
        oe_l_d     = !((state_d == SETTLE) || (state_d == SAMPLE));
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= IDLE;
            steps_q     <= 5'd0;
            settle_q    <= 4'd0;
            cnt_out_q   <= 4'd0;
            exp_count_q <= 4'd0;
            pass_q      <= 1'b0;
            load_l_q    <= 1'b1;
            enable_l_q  <= 1'b1;
            oe_l_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            steps_q     <= steps_d;
            settle_q    <= settle_d;
            cnt_out_q   <= cnt_out_d;
            exp_count_q <= exp_count_d;
            pass_q      <= pass_d;
            load_l_q    <= load_l_d;
            enable_l_q  <= enable_l_d;
            oe_l_q      <= oe_l_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef COUNT16_CTRL_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign load_l    = load_l_q;
    assign enable_l  = enable_l_q;
    assign cnt_out   = cnt_out_q;
    assign oe_l      = oe_l_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign exp_count = exp_count_q;

endmodule

// File: tb/tb_count16_ctrl.sv
// Directed bench for count16_ctrl with a behavioural 4-bit counter on the bus and a queue of expected run results.
module tb_count16_ctrl;

    localparam int SETTLE_CYC = 1;

    logic       clk = 1'b0;
    logic       rst_l = 1'b1;
    logic       start = 1'b0;
    logic [3:0] start_val = 4'd0;
    logic [4:0] num_steps = 5'd0;
    logic [3:0] count_bus;
    logic       load_l, enable_l, oe_l, busy, done, pass;
    logic [3:0] cnt_out, exp_count;
    logic [7:0] err_cnt;

    logic [3:0] cntModel = 4'd0;
    logic       forceZero = 1'b0;
    logic [7:0] errModel = 8'd0;
    int         testsRun = 0;
    int         testsFailed = 0;
    logic       doneInReset = 1'b0;

    typedef struct {
        logic [3:0] startVal;
        logic [3:0] expCount;
        logic       pass;
        logic [7:0] errCnt;
        int         latency;
        int         enableCycles;
    } score_t;

    score_t scoreboard[$];

    count16_ctrl #(.SETTLE_CYC(SETTLE_CYC)) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .start     (start),
        .start_val (start_val),
        .num_steps (num_steps),
        .count_bus (count_bus),
        .load_l    (load_l),
        .enable_l  (enable_l),
        .cnt_out   (cnt_out),
        .oe_l      (oe_l),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .exp_count (exp_count),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // Counter model; the bus carries inverted junk whenever oe_l is not asserted.
    always @(posedge clk) begin
        if (!load_l) cntModel <= cnt_out;
        else if (!enable_l) cntModel <= cntModel + 4'd1;
    end

    assign count_bus = forceZero ? 4'h0 : (oe_l ? ~cntModel : cntModel);

    task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Caller must be at a negedge; pushes the expected run outcome and raises start.
    task applyStimulus(input logic [3:0] sv, input logic [4:0] ns, input logic fz);
        score_t s;
        s.startVal = sv;
        s.expCount = sv + ns[3:0];
        s.pass = !fz || (s.expCount == 4'h0);
`ifdef COUNT16_CTRL_ERRCNT_EN
        if (!s.pass && errModel != 8'hFF) errModel = errModel + 8'd1;
`endif
        s.errCnt = errModel;
        s.latency = int'(ns) + SETTLE_CYC + 2;
        s.enableCycles = int'(ns);
        scoreboard.push_back(s);
        start_val = sv;
        num_steps = ns;
        forceZero = fz;
        start = 1'b1;
    endtask

    task waitForDone(input logic holdStart, input logic [3:0] nextSv, input logic [4:0] nextNs);
        score_t s;
        int     acceptEdges, k, loadCnt, enCnt;
        bit     seen, overlap, oeBad;
        seen = 0;
        acceptEdges = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            acceptEdges++;
            @(negedge clk);
            if (busy) seen = 1;
        end
        checkOutput("accepted on first edge", acceptEdges, 1);
        if (holdStart) begin
            start_val = nextSv;
            num_steps = nextNs;
        end else begin
            start = 1'b0;
        end
        s = scoreboard.pop_front();
        checkOutput("load cnt_out", cnt_out, s.startVal);
        checkOutput("load exp_count", exp_count, s.startVal);
        checkOutput("pass cleared on start", pass, 1'b0);
        k = 0; loadCnt = 0; enCnt = 0; overlap = 0; oeBad = 0; seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (!load_l) loadCnt++;
            if (!enable_l) enCnt++;
            if (!load_l && !enable_l) overlap = 1;
            if (!oe_l && (!load_l || !enable_l || done)) oeBad = 1;
            if (done) seen = 1;
            else begin
                @(posedge clk);
                k++;
                @(negedge clk);
            end
        end
        checkOutput("done seen", seen, 1);
        checkOutput("done latency", k, s.latency);
        checkOutput("load_l low cycles", loadCnt, 1);
        checkOutput("enable_l low cycles", enCnt, s.enableCycles);
        checkOutput("load/enable overlap", overlap, 0);
        checkOutput("oe_l outside settle/sample", oeBad, 0);
        checkOutput("final exp_count", exp_count, s.expCount);
        checkOutput("pass", pass, s.pass);
        checkOutput("err_cnt", err_cnt, s.errCnt);
        checkOutput("cnt_out held", cnt_out, s.startVal);
        checkOutput("busy in done", busy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("done one cycle", done, 1'b0);
        checkOutput("idle after done", busy, 1'b0);
        checkOutput("pass held", pass, s.pass);
    endtask

    always @(negedge clk) begin
        if (!rst_l && done) doneInReset = 1'b1;
    end

    initial begin
        #1 rst_l = 1'b0;
        #2;
        checkOutput("reset load_l", load_l, 1'b1);
        checkOutput("reset enable_l", enable_l, 1'b1);
        checkOutput("reset oe_l", oe_l, 1'b1);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset exp_count", exp_count, 4'd0);
        repeat (2) @(negedge clk);
        rst_l = 1'b1;

        applyStimulus(4'd3, 5'd5, 1'b0);   waitForDone(1'b0, 4'd0, 5'd0);
        applyStimulus(4'd14, 5'd3, 1'b0);  waitForDone(1'b0, 4'd0, 5'd0);
        applyStimulus(4'd9, 5'd0, 1'b0);   waitForDone(1'b0, 4'd0, 5'd0);
        applyStimulus(4'd5, 5'd2, 1'b1);   waitForDone(1'b0, 4'd0, 5'd0);
        applyStimulus(4'd15, 5'd31, 1'b0); waitForDone(1'b0, 4'd0, 5'd0);

        // Start held for a whole run: mid-run value changes must be ignored.
        applyStimulus(4'd4, 5'd6, 1'b0);   waitForDone(1'b1, 4'hE, 5'd1);
        applyStimulus(4'hE, 5'd1, 1'b0);   waitForDone(1'b0, 4'd0, 5'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("no run without start", busy, 1'b0);

        // Asynchronous reset in the middle of COUNT.
        start_val = 4'd2;
        num_steps = 5'd12;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("in count before reset", enable_l, 1'b0);
        #2 rst_l = 1'b0;
        #1;
        checkOutput("async load_l", load_l, 1'b1);
        checkOutput("async enable_l", enable_l, 1'b1);
        checkOutput("async oe_l", oe_l, 1'b1);
        checkOutput("async cnt_out", cnt_out, 4'd0);
        checkOutput("async busy", busy, 1'b0);
        checkOutput("async done", done, 1'b0);
        checkOutput("async pass", pass, 1'b0);
        checkOutput("async exp_count", exp_count, 4'd0);
        checkOutput("async err_cnt", err_cnt, 8'd0);
        errModel = 8'd0;
        repeat (20) @(negedge clk);
        checkOutput("no done during reset", doneInReset, 1'b0);
        rst_l = 1'b1;
        applyStimulus(4'hB, 5'd4, 1'b0);   waitForDone(1'b0, 4'd0, 5'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
